// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch queue.
package fetch_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 32;

  // Fetch control states.
  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain
  } fetch_state_e;

  // One queued instruction together with the address it was fetched from.
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Bundle of the fetch unit's memory, redirect and decode-side signals.
// master: the fetch unit. slave: the environment (memory, branch unit, decode).
interface inst_fetch_queue_if;
  import fetch_pkg::*;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              fetch_err;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_err,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_err,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous in-order FIFO of fetched instructions with flush.
// Pointers carry one extra wrap bit so full and empty are exact.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_flush,
  input  logic         i_push,
  input  fetch_entry_t i_entry,
  input  logic         i_pop,
  output fetch_entry_t o_entry,
  output logic [AW:0]  o_count,
  output logic         o_full,
  output logic         o_empty
);

  fetch_entry_t r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_do_push;
  logic         w_do_pop;

  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (o_count == (AW + 1)'(DEPTH));
  assign w_do_push = i_push & ~o_full & ~i_flush;
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
  assign o_entry   = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; flush and reset both empty the queue.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty hides them.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_entry;
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: owns the PC, requests words from instruction memory under a
// credit limit, queues responses in order and hands them to decode. A redirect flushes the
// queue and discards responses still in flight.
// Optional: FETCH_MISALIGN_CHECK_EN flags misaligned redirect targets on fetch_err and parks
// fetch; without it fetch_err is 0 and the low two address bits are forced to 0.
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned       PC_STEP  = 4
) (
  input logic                clk,
  input logic                reset,
  inst_fetch_queue_if.master fetch_bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e      r_state, w_state_d;
  logic [ADDR_W-1:0] r_pc, w_pc_d;
  logic [ADDR_W-1:0] r_resp_pc, w_resp_pc_d;
  logic [CW-1:0]     r_out, w_out_d;
  logic [CW-1:0]     r_discard, w_discard_d;
  logic              r_err, w_err_d;

  logic [CW-1:0]     w_count;
  logic              w_full;
  logic              w_empty;
  fetch_entry_t      w_head;
  fetch_entry_t      w_push_entry;
  logic              w_req;
  logic              w_grant;
  logic              w_accept;
  logic              w_redirect;
  logic              w_misalign;
  logic [ADDR_W-1:0] w_redir_pc;
  logic [CW-1:0]     w_pending;
  logic [CW:0]       w_credit;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign w_redir_pc = fetch_bus.redirect_pc;
  assign w_misalign = |fetch_bus.redirect_pc[1:0];
`else
  logic w_unused_lsbs;
  assign w_unused_lsbs = ^fetch_bus.redirect_pc[1:0];
  assign w_redir_pc    = {fetch_bus.redirect_pc[ADDR_W-1:2], 2'b00};
  assign w_misalign    = 1'b0;
`endif

  assign w_redirect = fetch_bus.redirect_valid;
  // Queued plus in-flight words never exceed DEPTH, so responses always find a slot.
  assign w_credit   = (CW + 1)'(w_count) + (CW + 1)'(r_out);
  assign w_req      = (r_state == StFetch) && (w_credit < (CW + 1)'(DEPTH));
  assign w_grant    = w_req & fetch_bus.imem_gnt;
  assign w_accept   = fetch_bus.imem_rvalid & (r_discard == '0);
  // Everything still owed by memory once this cycle's grant and response are counted.
  assign w_pending  = r_discard + r_out + CW'(w_grant) - CW'(fetch_bus.imem_rvalid);

  assign w_push_entry = '{inst: fetch_bus.imem_rdata, pc: r_resp_pc};

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_flush (w_redirect),
    .i_push  (w_accept & ~w_redirect & ~w_full),
    .i_entry (w_push_entry),
    .i_pop   (fetch_bus.inst_ready & ~w_redirect),
    .o_entry (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign fetch_bus.imem_req   = w_req;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign fetch_bus.imem_addr  = w_req ? r_pc : '0;
`else
  assign fetch_bus.imem_addr  = w_req ? {r_pc[ADDR_W-1:2], 2'b00} : '0;
`endif
  assign fetch_bus.inst_valid = ~w_empty;
  assign fetch_bus.inst       = w_empty ? '0 : w_head.inst;
  assign fetch_bus.inst_pc    = w_empty ? '0 : w_head.pc;
  assign fetch_bus.fetch_err  = r_err;

  // Next-state: redirect overrides everything, otherwise normal grant/response accounting.
  always_comb begin
    w_state_d   = r_state;
    w_pc_d      = r_pc;
    w_resp_pc_d = r_resp_pc;
    w_out_d     = r_out;
    w_discard_d = r_discard;
    w_err_d     = r_err;
    if (w_redirect) begin
      w_pc_d      = w_redir_pc;
      w_resp_pc_d = w_redir_pc;
      w_out_d     = '0;
      w_discard_d = w_pending;
      w_err_d     = w_misalign;
      if (w_pending != '0) begin
        w_state_d = StDrain;
      end else if (w_misalign) begin
        w_state_d = StIdle;
      end else begin
        w_state_d = StFetch;
      end
    end else begin
      if (w_grant) w_pc_d = r_pc + ADDR_W'(PC_STEP);
      if (fetch_bus.imem_rvalid && (r_discard != '0)) w_discard_d = r_discard - 1'b1;
      w_out_d = r_out + CW'(w_grant) - CW'(w_accept);
      // Responses arrive in request order and requests are sequential from the last target.
      if (w_accept) w_resp_pc_d = r_resp_pc + ADDR_W'(PC_STEP);
      unique case (r_state)
        StIdle:  if (!r_err) w_state_d = StFetch;
        StFetch: w_state_d = StFetch;
        StDrain: if (r_discard == '0) w_state_d = r_err ? StIdle : StFetch;
        default: w_state_d = StIdle;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_pc      <= RESET_PC;
      r_resp_pc <= RESET_PC;
      r_out     <= '0;
      r_discard <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_pc      <= w_pc_d;
      r_resp_pc <= w_resp_pc_d;
      r_out     <= w_out_d;
      r_discard <= w_discard_d;
      r_err     <= w_err_d;
    end
  end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Fetch stage directly upstream of the instruction splitter/decode stage.
- Owns the program counter and issues word requests to instruction memory over a request/grant bus.
- Buffers returned 32-bit instruction words in a small in-order queue.
- Presents one instruction per cycle to decode over a valid/ready handshake; supports a redirect (branch/jump) that flushes queued and in-flight fetches.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  request valid to instruction memory.
- imem_addr  out  32  byte address of request; stable while imem_req=1 and imem_gnt=0.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid; responses return in request order, at least 1 cycle after grant.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch address.
- inst_valid  out  1  head of queue valid to decode.
- inst_ready  in  1  decode accepts head.
- inst  out  32  instruction word; opcode in [31:26], rs in [25:21], rt in [20:16], imm in [15:0].
- inst_pc  out  32  address of inst.
- fetch_err  out  1  see Optional Feature; tied 0 when the feature is compiled out.

Behaviour:
- Reset, synchronous:
  - pc=RESET_PC; queue empty; outstanding=0; discard=0; state=IDLE.
  - All outputs 0 (imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_err).
- States:
  - IDLE: one cycle after reset deassertion, go to FETCH.
  - FETCH: normal operation.
  - DRAIN: discarding in-flight responses after a redirect.
- Credit rule:
  - imem_req=1 in FETCH only when (count + outstanding) < DEPTH.
  - This guarantees every response finds a free slot, so imem_rvalid is never back-pressured.
- On imem_req & imem_gnt: outstanding+1, pc += PC_STEP (32-bit wrap, no flag).
- On imem_rvalid:
  - If discard>0: discard-1, data dropped.
  - Else: push {imem_rdata, pc_of_request} and outstanding-1.
  - Request PCs are tracked in a DEPTH-entry tag FIFO, or inst_pc is derived from a per-entry stored address.
- Pop:
  - inst_valid = queue non-empty.
  - Pop on inst_valid & inst_ready.
  - Push and pop in the same cycle keep count unchanged.
  - Full and empty are exact; pointers are log2(DEPTH)+1 bits.
- Latency: the word returned at cycle N appears at inst with inst_valid=1 at cycle N+1 (registered queue output). There is no bypass path.
- Redirect (highest priority, takes effect in the cycle it is sampled):
  - Queue cleared; inst_valid=0 next cycle; pop in the same cycle ignored.
  - pc=redirect_pc.
  - discard += outstanding, counting any response arriving in the same cycle correctly.
  - outstanding=0.
  - Go to DRAIN if the resulting discard>0, else FETCH.
- A request granted in the redirect cycle is counted into discard.
- DRAIN:
  - imem_req=0.
  - Return to FETCH the cycle after discard reaches 0.
- A second redirect during DRAIN updates pc and remains in DRAIN.
- imem_req must not drop while ungranted, except on redirect or reset.
- Reset mid-operation: all state is cleared. Late memory responses after reset are the memory's responsibility and are not discarded.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN
- With the macro defined:
  - A redirect_pc with [1:0]≠0 sets fetch_err=1 (sticky until reset or the next aligned redirect).
  - Enters DRAIN, then parks in IDLE with no requests.
- Without the macro:
  - fetch_err is constant 0.
  - The low two address bits are forced to 0 on imem_addr.

Decomposition:
- Package fetch_pkg:
  - INST_W=32 and ADDR_W=32.
  - State enum {IDLE, FETCH, DRAIN}.
  - Queue entry struct {inst, pc}.
- One natural sub-module: fetch_fifo, a synchronous DEPTH-entry FIFO with flush, push, pop, count, full and empty.

Test Plan:
- Sequential fetch, memory grants every cycle with 1-cycle response, inst_ready=1 → inst_pc values 0x0,0x4,0x8,0xC in consecutive cycles; first inst_valid 3 cycles after reset release.
- inst_ready=0 with DEPTH=4 → exactly 4 requests granted, then imem_req=0; raising inst_ready resumes requests with no lost or duplicated words.
- Redirect to 0x100 with 2 requests outstanding → the 2 following responses are dropped, state goes DRAIN→FETCH, next inst_pc=0x100.
- Redirect and pop in the same cycle → popped word is not delivered, inst_valid=0 next cycle, queue count=0.
- Grant held off 5 cycles → imem_addr is stable for all 5 cycles and pc advances only once.
- With FETCH_MISALIGN_CHECK_EN: redirect_pc=0x102 → fetch_err=1 and no further imem_req; a subsequent redirect to 0x200 clears fetch_err and fetch resumes.
